sincos_phase_gen: RTL and testbench
===================================

Name: sincos_phase_gen

Overview:
- NCO phase accumulator plus quadrant folder; sits directly upstream of cosine_int and its 1024-entry coefficient ROM.
- Produces the folded angle `a`, the sign `s` and the ROM address `rom_addr`, all in the same cycle, plus a valid strobe.
- ROM read latency is fixed at 2 cycles, which gives the a-to-rom_d skew that cosine_int requires.

Parameters:
- NBP, 32, phase accumulator width in bits.
- NBA, 22, full-turn angle bits delivered downstream; must satisfy 13 <= NBA <= NBP.
- ROM_AW, 10, ROM address bits; equals NBA-12.

Ports:
- c, input, 1, clock.
- r, input, 1, reset; synchronous, active-high.
- freq, input, NBP, frequency tuning word.
- freq_we, input, 1, load freq into the internal frequency register.
- phase_ofs, input, NBP, static phase offset added after the accumulator.
- en, input, 1, advance the accumulator one step and launch one sample.
- sync, input, 1, zero the accumulator.
- a, output, NBA-2, folded angle within a quadrant.
- s, output, 1, 1 = cosine positive (quadrants 0 and 3).
- rom_addr, output, ROM_AW, coarse ROM address, equal to a[NBA-3:NBA-12].
- v, output, 1, a/s/rom_addr valid.

Behaviour:
- Reset (r=1 at an edge): acc, freq_q and all pipeline registers go to 0; outputs a=0, s=0, rom_addr=0, v=0. A reset mid-stream drops all in-flight samples on that edge; no partial output follows.
- Frequency load: freq_we=1 gives freq_q <= freq. The new value is first used by an en in the following cycle.
- Accumulator:
  - en=1 gives acc <= acc + freq_q, modulo 2^NBP; the wrap is silent.
  - sync=1 gives acc <= 0 and overrides en on the same edge.
  - The value sampled into the pipeline is the pre-update acc. The first sample after sync therefore has phase 0 + phase_ofs.
- Stage 1: ph <= acc + phase_ofs (mod 2^NBP); v1 <= en.
- Stage 2: t <= ph[NBP-1:NBP-NBA] (truncation, no rounding); v2 <= v1.
- Stage 3, quadrant fold; outputs are registered:
  - Let q = t[NBA-1:NBA-2] and m = t[NBA-3:0].
  - q=0: a=m, s=1.
  - q=1: a=~m, s=0.
  - q=2: a=m, s=0.
  - q=3: a=~m, s=1.
  - rom_addr = the fold result's top ROM_AW bits; v <= v2.
  - The ones'-complement mirror implies a half-LSB phase offset, which the ROM table generator accounts for.
- Latency: en at cycle N gives v=1 at N+3, with a, s and rom_addr coincident. Throughput is one sample per cycle.
- When v=0, a, s and rom_addr hold their last values; downstream ignores them.
- en=0 cycles insert bubbles; acc does not advance.

Optional Feature:
- Macro: SINCOS_PHASE_DITHER_EN.
- Defined:
  - A 24-bit Galois LFSR (taps 24,23,22,17, seed 24'h1, reset to seed) advances on every en=1 cycle.
  - Its low NBP-NBA bits are added to ph before truncation in stage 2, with carry into t. This adds no latency.
  - sync reseeds the LFSR.
- Undefined: plain truncation; no LFSR logic is present.

Decomposition:
- Package sincos_pkg:
  - ROM_AW = 10 and ROM_LAT = 2.
  - Quadrant encoding constants Q0..Q3.
  - The LFSR seed and tap mask.
- Sub-module sincos_quad_fold:
  - One registered stage holding the fold and the rom_addr slice.
  - Reused later by a sine variant with q remapped.

Test Plan:
- Reset, then freq=32'h4000_0000, freq_we, then en held high. Required first four v samples, with v asserting 3 cycles after en:
  - (a=20'h00000, s=1)
  - (a=20'hFFFFF, s=0)
  - (a=20'h00000, s=0)
  - (a=20'hFFFFF, s=1)
- freq=32'h0000_0400 (1 LSB of t), 4096 samples. Required:
  - In q0, a increments 0,1,2,… and rom_addr steps every 1024 samples.
  - a stays monotonic within each quadrant and wraps cleanly at 2^32.
- sync asserted together with en after 100 steps. Required: the next accumulated sample is phase 0, i.e. the sample after the synced edge has a=0 and s=1 with phase_ofs=0.
- phase_ofs=32'h8000_0000 with freq=0. Required: constant a=0, s=0, v tracking en delayed 3.
- Toggle en 1,0,1,1,0. Required: v pattern is the same, delayed exactly 3 cycles. Assert r during a burst; required: v=0 on the next edge and all outputs 0.
- With SINCOS_PHASE_DITHER_EN, freq=0, phase_ofs=32'h0000_0200. Required: the t LSB toggles pseudo-randomly with a mean of about 0.5 over 10000 samples. Without the macro, t is constant 0.

Source files
------------

// File: rtl/sincos_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sincos_pkg : shared constants for the sin/cos phase generator      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sincos_pkg;

  localparam int ROM_AW  = 10;
  localparam int ROM_LAT = 2;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  // Galois LFSR, taps 24,23,22,17 (right-shifting form)
  localparam logic [23:0] LFSR_SEED = 24'h000001;
  localparam logic [23:0] LFSR_TAPS = 24'hE10000;

  function automatic logic [23:0] lfsr_step(input logic [23:0] cur);
    lfsr_step = {1'b0, cur[23:1]} ^ (cur[0] ? LFSR_TAPS : 24'h000000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sincos_quad_fold.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sincos_quad_fold : registered quadrant fold plus ROM address slice |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sincos_quad_fold #(
  parameter int NBA    = 22,
  parameter int ROM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NBA-1:0]    t,
  input  logic              v_in,
  output logic [NBA-3:0]    a,
  output logic              s,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              v
);
  import sincos_pkg::*;

  logic [1:0]     q;
  logic [NBA-3:0] m;
  logic [NBA-3:0] a_d, a_q;
  logic           s_d, s_q;
  logic           v_d, v_q;

  assign q = t[NBA-1:NBA-2];
  assign m = t[NBA-3:0];

  // a and s only move on valid samples; otherwise they hold.
  always_comb begin
    a_d = a_q;
    s_d = s_q;
    v_d = v_in;
    if (v_in) begin
      case (quad_e'(q))
        Q0:      begin a_d = m;  s_d = 1'b1; end
        Q1:      begin a_d = ~m; s_d = 1'b0; end
        Q2:      begin a_d = m;  s_d = 1'b0; end
        default: begin a_d = ~m; s_d = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      s_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      a_q <= a_d;
      s_q <= s_d;
      v_q <= v_d;
    end
  end

  assign a        = a_q;
  assign s        = s_q;
  assign v        = v_q;
  assign rom_addr = a_q[NBA-3 -: ROM_AW];

endmodule
`default_nettype wire

// File: rtl/sincos_phase_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sincos_phase_gen : NCO accumulator + quadrant folder for cosine_int |
// | Optional macro SINCOS_PHASE_DITHER_EN adds LFSR truncation dither.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sincos_phase_gen #(
  parameter int NBP    = 32,
  parameter int NBA    = 22,
  parameter int ROM_AW = 10
) (
  input  logic              c,
  input  logic              r,
  input  logic [NBP-1:0]    freq,
  input  logic              freq_we,
  input  logic [NBP-1:0]    phase_ofs,
  input  logic              en,
  input  logic              sync,
  output logic [NBA-3:0]    a,
  output logic              s,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              v
);
  import sincos_pkg::*;

  logic [NBP-1:0] freq_d, freq_q;
  logic [NBP-1:0] acc_d,  acc_q;
  logic [NBP-1:0] ph_d,   ph_q;
  logic           v1_d,   v1_q;
  logic [NBA-1:0] t_d,    t_q;
  logic           v2_d,   v2_q;

`ifdef SINCOS_PHASE_DITHER_EN
  logic [23:0]    lfsr_d, lfsr_q;
  logic [NBP-1:0] dith;

  generate
    if (NBP > NBA) begin : g_dith
      assign dith = {{NBA{1'b0}}, lfsr_q[NBP-NBA-1:0]};
    end else begin : g_no_dith
      assign dith = '0;
    end
  endgenerate

  always_comb begin
    lfsr_d = lfsr_q;
    if (sync) begin
      lfsr_d = LFSR_SEED;
    end else if (en) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge c) begin
    if (r) lfsr_q <= LFSR_SEED;
    else   lfsr_q <= lfsr_d;
  end
`endif

  // Pipeline samples the pre-update accumulator, so sync's first sample is 0.
  always_comb begin
    freq_d = freq_we ? freq : freq_q;
    acc_d  = acc_q;
    if (sync) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + freq_q;
    end
    ph_d = acc_q + phase_ofs;
    v1_d = en;
`ifdef SINCOS_PHASE_DITHER_EN
    t_d  = NBA'((ph_q + dith) >> (NBP - NBA));
`else
    t_d  = NBA'(ph_q >> (NBP - NBA));
`endif
    v2_d = v1_q;
  end

  always_ff @(posedge c) begin
    if (r) begin
      freq_q <= '0;
      acc_q  <= '0;
      ph_q   <= '0;
      v1_q   <= 1'b0;
      t_q    <= '0;
      v2_q   <= 1'b0;
    end else begin
      freq_q <= freq_d;
      acc_q  <= acc_d;
      ph_q   <= ph_d;
      v1_q   <= v1_d;
      t_q    <= t_d;
      v2_q   <= v2_d;
    end
  end

  sincos_quad_fold #(
    .NBA    (NBA),
    .ROM_AW (ROM_AW)
  ) u_fold (
    .clk      (c),
    .rst      (r),
    .t        (t_q),
    .v_in     (v2_q),
    .a        (a),
    .s        (s),
    .rom_addr (rom_addr),
    .v        (v)
  );

endmodule
`default_nettype wire

// File: tb/tb_sincos_phase_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sincos_phase_gen : directed self-checking bench                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sincos_phase_gen;

  logic        c = 1'b0;
  logic        r;
  logic [31:0] freq;
  logic        freq_we;
  logic [31:0] phase_ofs;
  logic        en;
  logic        sync;
  logic [19:0] a;
  logic        s;
  logic [9:0]  rom_addr;
  logic        v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 c = ~c;

  sincos_phase_gen #(
    .NBP    (32),
    .NBA    (22),
    .ROM_AW (10)
  ) dut (
    .c         (c),
    .r         (r),
    .freq      (freq),
    .freq_we   (freq_we),
    .phase_ofs (phase_ofs),
    .en        (en),
    .sync      (sync),
    .a         (a),
    .s         (s),
    .rom_addr  (rom_addr),
    .v         (v)
  );

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // Clears the accumulator and loads a tuning word / offset, with en low.
  task automatic setup(input logic [31:0] f, input logic [31:0] ofs);
    en        = 1'b0;
    sync      = 1'b1;
    freq      = f;
    freq_we   = 1'b1;
    phase_ofs = ofs;
    tick();
    sync    = 1'b0;
    freq_we = 1'b0;
  endtask

  task automatic test_reset();
    r = 1'b1; en = 1'b0; sync = 1'b0; freq_we = 1'b0; freq = '0; phase_ofs = '0;
    tick();
    tick();
    r = 1'b0;
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL reset_v: got %b want 0", v); end
    n_cmp++; if (a !== 20'h0) begin n_bad++; $display("FAIL reset_a: got %h want 00000", a); end
    n_cmp++; if (s !== 1'b0) begin n_bad++; $display("FAIL reset_s: got %b want 0", s); end
    n_cmp++; if (rom_addr !== 10'h0) begin n_bad++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
  endtask

  task automatic test_quadrants();
    logic [19:0] exp_a  [4] = '{20'h00000, 20'hFFFFF, 20'h00000, 20'hFFFFF};
    logic        exp_s  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [9:0]  exp_ra [4] = '{10'h000, 10'h3FF, 10'h000, 10'h3FF};
    setup(32'h4000_0000, 32'h0);
    en = 1'b1;
    tick();
    tick();
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL quad_latency_early: v=%b want 0 two edges after en", v); end
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({v, s, a, rom_addr} !== {1'b1, exp_s[k], exp_a[k], exp_ra[k]}) begin
        n_bad++;
        $display("FAIL quad_sample[%0d]: got v=%b s=%b a=%h ra=%h want v=1 s=%b a=%h ra=%h",
                 k, v, s, a, rom_addr, exp_s[k], exp_a[k], exp_ra[k]);
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_ramp();
    logic [19:0] wrap_a [8] = '{20'h3, 20'h2, 20'h1, 20'h0, 20'h0, 20'h1, 20'h2, 20'h3};
    setup(32'h0000_0400, 32'h0);
    en = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 4096; k++) begin
      n_cmp++;
      if ({v, s, rom_addr, a} !== {1'b1, 1'b1, 10'(k >> 10), 20'(k)}) begin
        n_bad++;
        $display("FAIL ramp[%0d]: got v=%b s=%b ra=%h a=%h want v=1 s=1 ra=%h a=%h",
                 k, v, s, rom_addr, a, 10'(k >> 10), 20'(k));
      end
      tick();
    end
    en = 1'b0;
    // Straddle the 2^32 wrap: q3 mirror counts down, then q0 counts up.
    setup(32'h0000_0400, 32'hFFFF_F000);
    en = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if ({v, s, rom_addr, a} !== {1'b1, 1'b1, 10'h0, wrap_a[k]}) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got v=%b s=%b ra=%h a=%h want v=1 s=1 ra=000 a=%h",
                 k, v, s, rom_addr, a, wrap_a[k]);
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_sync();
    setup(32'h0100_0000, 32'h0);
    en = 1'b1;
    repeat (100) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    en = 1'b0;
    tick();
    // Pre-sync sample: phase 0x6400_0000 -> q1, a = ~0x90000.
    n_cmp++;
    if ({v, s, a, rom_addr} !== {1'b1, 1'b0, 20'h6FFFF, 10'h1BF}) begin
      n_bad++;
      $display("FAIL sync_pre: got v=%b s=%b a=%h ra=%h want v=1 s=0 a=6ffff ra=1bf", v, s, a, rom_addr);
    end
    tick();
    n_cmp++;
    if ({v, s, a, rom_addr} !== {1'b1, 1'b1, 20'h00000, 10'h000}) begin
      n_bad++;
      $display("FAIL sync_zero: got v=%b s=%b a=%h ra=%h want v=1 s=1 a=00000 ra=000", v, s, a, rom_addr);
    end
    tick();
    n_cmp++;
    if ({v, s, a} !== {1'b0, 1'b1, 20'h00000}) begin
      n_bad++;
      $display("FAIL sync_hold: got v=%b s=%b a=%h want v=0 s=1 a=00000", v, s, a);
    end
  endtask

  task automatic test_back_to_back();
    logic pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_v;
    setup(32'h0, 32'h8000_0000);
    tick(); tick(); tick();
    for (int j = 0; j < 8; j++) begin
      en = pat[j];
      tick();
      exp_v = (j >= 2) ? pat[j-2] : 1'b0;
      n_cmp++;
      if (v !== exp_v) begin
        n_bad++;
        $display("FAIL bubble_v[%0d]: got %b want %b", j, v, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if ({s, a, rom_addr} !== {1'b0, 20'h0, 10'h0}) begin
          n_bad++;
          $display("FAIL bubble_data[%0d]: got s=%b a=%h ra=%h want s=0 a=00000 ra=000", j, s, a, rom_addr);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_midstream();
    setup(32'h0000_0400, 32'h4000_0000);
    en = 1'b1;
    repeat (5) tick();
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_v: got %b want 1", v); end
    r = 1'b1;
    tick();
    n_cmp++;
    if ({v, s, a, rom_addr} !== {1'b0, 1'b0, 20'h0, 10'h0}) begin
      n_bad++;
      $display("FAIL midrst_outputs: got v=%b s=%b a=%h ra=%h want all 0", v, s, a, rom_addr);
    end
    r  = 1'b0;
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL midrst_flush[%0d]: v=%b want 0", j, v); end
    end
  endtask

  task automatic test_dither();
`ifdef SINCOS_PHASE_DITHER_EN
    int ones = 0;
    int wide = 0;
    setup(32'h0, 32'h0000_0200);
    en = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 10000; k++) begin
      if (a[0]) ones++;
      if (a[19:1] != 19'h0 || s !== 1'b1 || v !== 1'b1) wide++;
      tick();
    end
    en = 1'b0;
    n_cmp++; if (wide !== 0) begin n_bad++; $display("FAIL dither_range: %0d samples outside {0,1}/s=1/v=1, want 0", wide); end
    n_cmp++;
    if (ones < 4000 || ones > 6000) begin
      n_bad++;
      $display("FAIL dither_mean: got %0d ones in 10000 want 4000..6000", ones);
    end
`else
    int bad = 0;
    setup(32'h0, 32'h0000_0200);
    en = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 64; k++) begin
      if ({v, s, a} !== {1'b1, 1'b1, 20'h0}) bad++;
      tick();
    end
    en = 1'b0;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL trunc_const: got %0d nonzero samples want 0", bad); end
`endif
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_ramp();
    test_sync();
    test_back_to_back();
    test_reset_midstream();
    test_dither();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
